// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction-memory and decode handshakes of the fetch front end
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [31:0]     inst_data;
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch with in-flight pc tags, instruction FIFO and redirect flush
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d, tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [XLEN-1:0] tag_mem  [DEPTH];
  logic            credit_ok, req_fire, rsp_fire, pop, push, redirect;
  assign credit_ok          = ({1'b0, count_q} + {1'b0, out_q}) < (CW + 1)'(DEPTH);
  assign bus.imem_req_valid = reset & credit_ok;
  assign bus.imem_req_addr  = reset ? fetch_pc_q : '0;
  assign bus.inst_valid     = reset & (count_q != '0);
  assign bus.inst_pc        = bus.inst_valid ? pc_mem[rd_q] : '0;
  assign bus.inst_data      = bus.inst_valid ? data_mem[rd_q] : '0;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_fire           = bus.imem_rsp_valid;
  assign pop                = bus.inst_valid & bus.inst_ready;
  assign redirect           = bus.redirect_valid;
  assign push               = rsp_fire & (drop_q == '0) & ~redirect;
  // next-state: credits, drop accounting, FIFO and tag-queue pointers, redirect flush
  always_comb begin
    out_d      = out_q + CW'(req_fire) - CW'(rsp_fire);
    fetch_pc_d = redirect ? (bus.redirect_pc & ~XLEN'(3)) : req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    drop_d     = redirect ? out_d : (rsp_fire && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    rd_d       = redirect ? '0 : pop ? rd_q + 1'b1 : rd_q;
    wr_d       = redirect ? '0 : push ? wr_q + 1'b1 : wr_q;
    tag_wr_d   = req_fire ? tag_wr_q + 1'b1 : tag_wr_q;
    tag_rd_d   = rsp_fire ? tag_rd_q + 1'b1 : tag_rd_q;
  end
  // control state; reset (active low) overrides redirect and all handshakes
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end
  // storage: in-flight pc tags on request, {tag, instruction} into FIFO on kept response
  always_ff @(posedge clk) begin
    if (reset && req_fire) tag_mem[tag_wr_q] <= fetch_pc_q;
    if (reset && push) begin
      pc_mem[wr_q]   <= tag_mem[tag_rd_q];
      data_mem[wr_q] <= bus.imem_rsp_data;
    end
  end
  // a response with nothing outstanding breaks the memory protocol
  always_ff @(posedge clk) begin
    if (reset && bus.imem_rsp_valid) assert (out_q != '0);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, credit stall, ready toggling, redirects, wrap and reset
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  bit          hold = 1'b0;
  int          passed = 0;
  int          total = 0;
  logic [31:0] q[$];
  fetch_unit_if #(.XLEN(32)) ifc ();
  fetch_unit #(.XLEN(32), .RESET_PC(32'h100), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(ifc));
  always #5 clk = ~clk;
  task automatic tick();
    logic        f;
    logic [31:0] a;
    @(negedge clk);
    f = ifc.imem_req_valid & ifc.imem_req_ready;
    a = ifc.imem_req_addr;
    @(posedge clk);
    #1;
    if (!reset) q.delete();
    else if (f) q.push_back(a);
    if (reset && !hold && q.size() > 0) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = ~q.pop_front();
    end else begin
      ifc.imem_rsp_valid = 1'b0;
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  initial begin
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.imem_req_ready = 1'b1;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    ifc.inst_ready     = 1'b1;
    tick();
    tick();
    chk("rst_req_valid", 32'(ifc.imem_req_valid), 0);
    chk("rst_inst_valid", 32'(ifc.inst_valid), 0);
    chk("rst_inst_pc", ifc.inst_pc, 0);
    chk("rst_inst_data", ifc.inst_data, 0);
    reset = 1'b1;
    #1;
    chk("t1_req_valid", 32'(ifc.imem_req_valid), 1);
    chk("t1_addr0", ifc.imem_req_addr, 32'h100);
    tick();
    chk("t1_addr1", ifc.imem_req_addr, 32'h104);
    chk("t1_no_inst_yet", 32'(ifc.inst_valid), 0);
    tick();
    chk("t1_inst_valid", 32'(ifc.inst_valid), 1);
    chk("t1_inst_pc0", ifc.inst_pc, 32'h100);
    chk("t1_inst_data0", ifc.inst_data, ~32'h100);
    tick();
    chk("t1_inst_pc1", ifc.inst_pc, 32'h104);
    ifc.inst_ready = 1'b0;
    tick();
    tick();
    chk("t2_credit_stop", 32'(ifc.imem_req_valid), 0);
    tick();
    chk("t2_still_stop", 32'(ifc.imem_req_valid), 0);
    chk("t2_head_held", ifc.inst_pc, 32'h104);
    tick();
    chk("t2_full_stop", 32'(ifc.imem_req_valid), 0);
    ifc.inst_ready = 1'b1;
    tick();
    chk("t2_pop_pc", ifc.inst_pc, 32'h108);
    chk("t2_req_resume", 32'(ifc.imem_req_valid), 1);
    chk("t2_req_addr", ifc.imem_req_addr, 32'h114);
    tick();
    chk("t2_pc_10c", ifc.inst_pc, 32'h10C);
    tick();
    tick();
    chk("t2_pc_114", ifc.inst_pc, 32'h114);
    ifc.imem_req_ready = 1'b0;
    tick();
    chk("t3_pc_118", ifc.inst_pc, 32'h118);
    chk("t3_addr_held", ifc.imem_req_addr, 32'h120);
    ifc.imem_req_ready = 1'b1;
    tick();
    chk("t3_pc_11c", ifc.inst_pc, 32'h11C);
    chk("t3_addr_124", ifc.imem_req_addr, 32'h124);
    ifc.imem_req_ready = 1'b0;
    tick();
    chk("t3_pc_120", ifc.inst_pc, 32'h120);
    chk("t3_addr_held2", ifc.imem_req_addr, 32'h124);
    ifc.imem_req_ready = 1'b1;
    tick();
    chk("t3_empty", 32'(ifc.inst_valid), 0);
    chk("t3_addr_128", ifc.imem_req_addr, 32'h128);
    tick();
    chk("t3_pc_124", ifc.inst_pc, 32'h124);
    hold = 1'b1;
    tick();
    chk("t4_pc_128", ifc.inst_pc, 32'h128);
    tick();
    tick();
    chk("t4_addr_138", ifc.imem_req_addr, 32'h138);
    ifc.imem_req_ready = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h2002;
    tick();
    ifc.redirect_valid = 1'b0;
    ifc.imem_req_ready = 1'b1;
    hold = 1'b0;
    chk("t4_flushed", 32'(ifc.inst_valid), 0);
    chk("t4_req_valid", 32'(ifc.imem_req_valid), 1);
    chk("t4_redir_addr", ifc.imem_req_addr, 32'h2000);
    tick();
    chk("t4_credit_full", 32'(ifc.imem_req_valid), 0);
    chk("t4_stale_a", 32'(ifc.inst_valid), 0);
    tick();
    chk("t4_stale_b", 32'(ifc.inst_valid), 0);
    chk("t4_addr_2004", ifc.imem_req_addr, 32'h2004);
    tick();
    chk("t4_stale_c", 32'(ifc.inst_valid), 0);
    tick();
    chk("t4_stale_d", 32'(ifc.inst_valid), 0);
    tick();
    chk("t4_first_valid", 32'(ifc.inst_valid), 1);
    chk("t4_first_pc", ifc.inst_pc, 32'h2000);
    chk("t4_first_data", ifc.inst_data, ~32'h2000);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h3000;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("t5_flushed", 32'(ifc.inst_valid), 0);
    chk("t5_redir_addr", ifc.imem_req_addr, 32'h3000);
    tick();
    chk("t5_stale_a", 32'(ifc.inst_valid), 0);
    tick();
    chk("t5_stale_b", 32'(ifc.inst_valid), 0);
    tick();
    chk("t5_first_valid", 32'(ifc.inst_valid), 1);
    chk("t5_first_pc", ifc.inst_pc, 32'h3000);
    ifc.imem_req_ready = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    ifc.redirect_valid = 1'b0;
    ifc.imem_req_ready = 1'b1;
    chk("t6_flushed", 32'(ifc.inst_valid), 0);
    chk("t6_addr_top", ifc.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_addr_wrap", ifc.imem_req_addr, 32'h0);
    tick();
    chk("t6_top_valid", 32'(ifc.inst_valid), 1);
    chk("t6_top_pc", ifc.inst_pc, 32'hFFFF_FFFC);
    chk("t6_top_data", ifc.inst_data, 32'h3);
    reset = 1'b0;
    tick();
    chk("t6_rst_req_valid", 32'(ifc.imem_req_valid), 0);
    chk("t6_rst_addr", ifc.imem_req_addr, 0);
    chk("t6_rst_inst_valid", 32'(ifc.inst_valid), 0);
    chk("t6_rst_inst_pc", ifc.inst_pc, 0);
    chk("t6_rst_inst_data", ifc.inst_data, 0);
    reset = 1'b1;
    #1;
    chk("t6_restart_valid", 32'(ifc.imem_req_valid), 1);
    chk("t6_restart_addr", ifc.imem_req_addr, 32'h100);
    tick();
    chk("t6_restart_addr1", ifc.imem_req_addr, 32'h104);
    chk("t6_restart_empty", 32'(ifc.inst_valid), 0);
    tick();
    chk("t6_restart_pc", ifc.inst_pc, 32'h100);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
